// File: rtl/conv_row_feeder.sv
// conv_row_feeder: four-line-buffer column feeder for the 5x5 conv PE array.
// Build option: define ZERO_PAD_EN to emit zero-padded columns on rows 0..3.
module conv_row_feeder #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_sof,
  input  logic [DATA_W-1:0]          s_data,
  output logic [DATA_W-1:0]          R1,
  output logic [DATA_W-1:0]          R2,
  output logic [DATA_W-1:0]          R3,
  output logic [DATA_W-1:0]          R4,
  output logic [DATA_W-1:0]          R5,
  output logic [2:0]                 sel,
  output logic                       col_valid,
  output logic [$clog2(IMG_H)-1:0]   row_idx,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_FILL = RW'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [2:0]    r_sel;

  logic [DATA_W-1:0] r_lb [4][IMG_W];

  logic [DATA_W-1:0] r_r1;
  logic [DATA_W-1:0] r_r2;
  logic [DATA_W-1:0] r_r3;
  logic [DATA_W-1:0] r_r4;
  logic [DATA_W-1:0] r_r5;
  logic [2:0]        r_osel;
  logic              r_col_valid;
  logic [RW-1:0]     r_row_idx;
  logic              r_frame_done;

  logic          w_ready;
  logic          w_take;
  logic          w_emit;
  logic          w_end_fill;
  logic          w_end_frame;
  logic [CW-1:0] w_pc;
  logic [RW-1:0] w_pr;
  logic [2:0]    w_psel;
  logic          w_col_end;
  logic [1:0]    w_b0;
  logic [1:0]    w_b1;
  logic [1:0]    w_b2;
  logic [1:0]    w_b3;

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_rd3;
  logic [DATA_W-1:0] w_rd4;
  logic [DATA_W-1:0] w_c1;
  logic [DATA_W-1:0] w_c2;
  logic [DATA_W-1:0] w_c3;
  logic [DATA_W-1:0] w_c4;

  assign w_end_fill  = (r_row == R_FILL) && (r_col == C_LAST);
  assign w_end_frame = (r_row == R_LAST) && (r_col == C_LAST);

  // An s_sof pixel always lands at (0,0), whatever the counters hold.
  assign w_pc   = s_sof ? '0 : r_col;
  assign w_pr   = s_sof ? '0 : r_row;
  assign w_psel = s_sof ? '0 : r_sel;

  assign w_col_end = (w_pc == C_LAST);

  // Bank b0 holds row r-4 (about to be overwritten); b3 holds row r-1.
  assign w_b0 = w_pr[1:0];
  assign w_b1 = w_pr[1:0] + 2'd1;
  assign w_b2 = w_pr[1:0] + 2'd2;
  assign w_b3 = w_pr[1:0] + 2'd3;

  assign w_rd1 = r_lb[w_b0][w_pc];
  assign w_rd2 = r_lb[w_b1][w_pc];
  assign w_rd3 = r_lb[w_b2][w_pc];
  assign w_rd4 = r_lb[w_b3][w_pc];

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_take      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_take = s_valid && s_sof;
        if (w_take) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_take = s_valid;
        if (w_take) begin
          if (s_sof)           w_state_nxt = ST_FILL;
          else if (w_end_fill) w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_take = s_valid;
        if (w_take) begin
          if (s_sof)            w_state_nxt = ST_FILL;
          else if (w_end_frame) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_ready     = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready = w_ready;

`ifdef ZERO_PAD_EN
  assign w_emit = w_take;
`else
  assign w_emit = w_take && !s_sof && (r_state == ST_STREAM);
`endif

  // Column taps; older rows above the frame top read as zero when padding.
  always_comb begin
    w_c1 = w_rd1;
    w_c2 = w_rd2;
    w_c3 = w_rd3;
    w_c4 = w_rd4;
`ifdef ZERO_PAD_EN
    if (w_pr < RW'(4)) w_c1 = '0;
    if (w_pr < RW'(3)) w_c2 = '0;
    if (w_pr < RW'(2)) w_c3 = '0;
    if (w_pr < RW'(1)) w_c4 = '0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Raster position and column phase of the next pixel.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_col <= '0;
      r_row <= '0;
      r_sel <= '0;
    end else if (w_take) begin
      if (w_col_end) begin
        r_col <= '0;
        r_sel <= '0;
        r_row <= (w_pr == R_LAST) ? '0 : w_pr + RW'(1);
      end else begin
        r_col <= w_pc + CW'(1);
        r_sel <= (w_psel == 3'd4) ? 3'd0 : w_psel + 3'd1;
        r_row <= w_pr;
      end
    end
  end

  // Line buffer write; reads above see the old contents this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n && w_take) r_lb[w_b0][w_pc] <= s_data;
  end

  // Registered column outputs and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_r1         <= '0;
      r_r2         <= '0;
      r_r3         <= '0;
      r_r4         <= '0;
      r_r5         <= '0;
      r_osel       <= '0;
      r_col_valid  <= 1'b0;
      r_row_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_col_valid  <= w_emit;
      r_frame_done <= (r_state == ST_DONE);
      if (w_emit) begin
        r_r1      <= w_c1;
        r_r2      <= w_c2;
        r_r3      <= w_c3;
        r_r4      <= w_c4;
        r_r5      <= s_data;
        r_osel    <= w_psel;
        r_row_idx <= w_pr;
      end
    end
  end

  assign R1         = r_r1;
  assign R2         = r_r2;
  assign R3         = r_r3;
  assign R4         = r_r4;
  assign R5         = r_r5;
  assign sel        = r_osel;
  assign col_valid  = r_col_valid;
  assign row_idx    = r_row_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_row_feeder.sv
// tb_conv_row_feeder: random-stimulus bench against a frame-image model.
// Honors ZERO_PAD_EN the same way as the design.
module tb_conv_row_feeder;

  localparam int W = 8;
  localparam int H = 6;
`ifdef ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int EXP_COLS = H * W;
`else
  localparam bit PAD = 1'b0;
  localparam int EXP_COLS = (H - 4) * W;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic       s_sof;
  logic [7:0] s_data;
  logic [7:0] R1, R2, R3, R4, R5;
  logic [2:0] sel;
  logic       col_valid;
  logic [$clog2(H)-1:0] row_idx;
  logic       frame_done;

  always #5 clk = ~clk;

  conv_row_feeder #(
    .IMG_W (W),
    .IMG_H (H),
    .DATA_W(8)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_data    (s_data),
    .R1        (R1),
    .R2        (R2),
    .R3        (R3),
    .R4        (R4),
    .R5        (R5),
    .sel       (sel),
    .col_valid (col_valid),
    .row_idx   (row_idx),
    .frame_done(frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the frame as an image, plus where the next pixel goes.
  logic [7:0] m_img [H][W];
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_r = 0;
  int         m_c = 0;

  logic [7:0] e_r [5];
  bit         e_valid;
  bit         e_fd;
  int         e_sel;
  int         e_row;

  int         col_cnt;
  int         fd_cnt;
  logic [7:0] first_r [5];
  logic [7:0] last_r  [5];
  logic [7:0] got_r   [5];

  task automatic cyc(input bit v, input bit sof, input bit rst,
                     input logic [7:0] d, output bit acc);
    bit rdy;
    bit take;
    int pr;
    int pc;
    @(negedge clk);
    s_valid = v;
    s_sof   = sof;
    reset_n = rst;
    s_data  = d;
    #1;
    rdy = !m_done;
    check("s_ready", 32'(s_ready), 32'(rdy));
    acc = v && rdy && !rst;
    e_valid = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_r      = 0;
      m_c      = 0;
      e_fd     = 1'b0;
      e_sel    = 0;
      e_row    = 0;
      for (int k = 0; k < 5; k++) e_r[k] = '0;
    end else begin
      e_fd   = m_done;
      m_done = 1'b0;
      take   = acc && (sof || m_active);
      if (take) begin
        if (sof) begin
          pr = 0;
          pc = 0;
          m_active = 1'b1;
        end else begin
          pr = m_r;
          pc = m_c;
        end
        m_img[pr][pc] = d;
        if (PAD || pr >= 4) begin
          e_valid = 1'b1;
          e_r[4]  = d;
          for (int k = 1; k <= 4; k++)
            e_r[4-k] = (pr >= k) ? m_img[pr-k][pc] : 8'h00;
          e_sel = pc % 5;
          e_row = pr;
        end
        if (pc == W - 1) begin
          m_c = 0;
          if (pr == H - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_r      = 0;
          end else begin
            m_r = pr + 1;
          end
        end else begin
          m_c = pc + 1;
          m_r = pr;
        end
      end
    end
    @(posedge clk);
    #1;
    got_r[0] = R1;
    got_r[1] = R2;
    got_r[2] = R3;
    got_r[3] = R4;
    got_r[4] = R5;
    check("col_valid", 32'(col_valid), 32'(e_valid));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    if (e_valid || rst) begin
      check("R1", 32'(R1), 32'(e_r[0]));
      check("R2", 32'(R2), 32'(e_r[1]));
      check("R3", 32'(R3), 32'(e_r[2]));
      check("R4", 32'(R4), 32'(e_r[3]));
      check("R5", 32'(R5), 32'(e_r[4]));
      check("sel", 32'(sel), 32'(e_sel));
      check("row_idx", 32'(row_idx), 32'(e_row));
    end
    if (col_valid === 1'b1) begin
      if (col_cnt == 0) first_r = got_r;
      last_r = got_r;
      col_cnt++;
    end
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom), a);
  endtask

  task automatic send(input bit sof, input logic [7:0] d, input int gap);
    bit acc;
    int n;
    n = 0;
    while (gap > 0 && $urandom_range(99) < gap && n < 20) begin
      idle(1);
      n++;
    end
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      cyc(1'b1, sof, 1'b0, d, acc);
      n++;
      if (!acc && n >= 4) begin
        check("send_timeout", 32'(acc), 32'd1);
        break;
      end
    end
  endtask

  // Sends pixels 0..npix-1 of a frame; ramp is 16*r+c, else random.
  task automatic frame(input bit ramp, input int gap, input int npix);
    logic [7:0] d;
    for (int i = 0; i < npix; i++) begin
      d = ramp ? 8'(16 * (i / W) + (i % W)) : 8'($urandom);
      send(i == 0, d, gap);
    end
  endtask

  task automatic chk_cols(input string tag, input logic [7:0] exp [5],
                          input logic [7:0] got [5]);
    for (int k = 0; k < 5; k++) check(tag, 32'(got[k]), 32'(exp[k]));
  endtask

  logic [7:0] exp_first [5];
  logic [7:0] exp_last  [5];

  initial begin
    bit a;
    for (int k = 0; k < 5; k++) begin
      exp_first[k] = PAD ? 8'h00 : 8'(16 * k);
      exp_last[k]  = 8'(16 * (k + 1) + 7);
    end
    col_cnt = 0;
    fd_cnt  = 0;
    reset_n = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);

    cyc(1'b0, 1'b0, 1'b1, 8'h00, a);
    cyc(1'b1, 1'b0, 1'b1, 8'h5a, a);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), a);

    col_cnt = 0;
    fd_cnt  = 0;
    frame(1'b1, 0, W * H);
    idle(3);
    check("ramp_cols", 32'(col_cnt), 32'(EXP_COLS));
    check("ramp_fd", 32'(fd_cnt), 32'd1);
    chk_cols("ramp_first", exp_first, first_r);
    chk_cols("ramp_last", exp_last, last_r);

    col_cnt = 0;
    fd_cnt  = 0;
    frame(1'b1, 40, W * H);
    idle(3);
    check("gap_cols", 32'(col_cnt), 32'(EXP_COLS));
    check("gap_fd", 32'(fd_cnt), 32'd1);
    chk_cols("gap_first", exp_first, first_r);
    chk_cols("gap_last", exp_last, last_r);

    frame(1'b1, 0, 4 * W + 3);
    cyc(1'b1, 1'b0, 1'b1, 8'(16 * 4 + 3), a);
    idle(2);
    col_cnt = 0;
    frame(1'b0, 20, W * H);
    idle(3);
    check("rst_cols", 32'(col_cnt), 32'(EXP_COLS));

    frame(1'b1, 0, 5 * W + 2);
    fd_cnt = 0;
    frame(1'b0, 0, W * H);
    idle(3);
    check("sof_fd", 32'(fd_cnt), 32'd1);

    for (int f = 0; f < 3; f++) begin
      col_cnt = 0;
      frame(1'b0, 40, W * H);
      idle(2);
      check("rand_cols", 32'(col_cnt), 32'(EXP_COLS));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
